// File: rtl/bit_serial_adder.sv
// Bit-serial adder: operands are shifted LSB-first through one full-adder slice,
// with the carry held in a flop between bits. Includes the one-bit full adder fa.

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic cy
);
    assign s  = a ^ b ^ ci;
    assign cy = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one operand bit added per clock, WIDTH clocks in total
// DONE  | single-cycle result-valid; start here re-launches without a gap
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   s_sr;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;

    logic               fa_s;
    logic               fa_cy;
    logic [WIDTH-1:0]   s_next;

    fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (fa_s),
        .cy (fa_cy)
    );

    // The newest sum bit enters at the MSB; after WIDTH shifts it lines up as the full result.
    assign s_next = {fa_s, s_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        s_sr    <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr    <= s_next[WIDTH-1:1];
                    carry_q <= fa_cy;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sum   <= s_next;
                        cout  <= fa_cy;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder against a cycle-timeline model
// that computes results with plain arithmetic.

module tb_bit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_err = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1..W = adding, W+1 = result cycle.
    int         m_phase = 0;
    logic [W:0] m_pending = '0;
    logic [W:0] m_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_result = '0;
        end else if (m_phase == 0 || m_phase == W + 1) begin
            if (start) begin
                m_pending = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_phase   = 1;
            end else begin
                m_phase = 0;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == W + 1) m_result = m_pending;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("model_busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
            chk("model_done", 32'(done), 32'(m_phase == W + 1));
            chk("model_sum",  32'(sum),  32'(m_result[W-1:0]));
            chk("model_cout", 32'(cout), 32'(m_result[W]));
        end
    end

    // Call at a negedge; returns at the negedge where done is high.
    task automatic wait_done();
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        chk("done_timeout", 32'(0), 32'(1));
    endtask

    // Call at a negedge; start is presented in the current cycle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    task automatic chk_res(input string name, input logic [W-1:0] es, input logic ec);
        chk({name, "_sum"},  32'(sum),  32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rs;

        // 1: reset held with start high
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk_res("rst", 8'h00, 1'b0);
        start = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2: basic op, latency and busy length
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 4 * W) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_len", 32'(cyc), 32'(W));
        chk("lat_done", 32'(done), 32'(1));
        chk_res("t2", 8'h7F, 1'b0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(0));

        // 3: carry chains
        do_op(8'hFF, 8'h01, 1'b0); chk_res("ff01", 8'h00, 1'b1);
        @(negedge clk);
        do_op(8'hFF, 8'hFF, 1'b1); chk_res("ffff1", 8'hFF, 1'b1);
        @(negedge clk);
        do_op(8'h00, 8'h00, 1'b1); chk_res("0001", 8'h01, 1'b0);
        @(negedge clk);

        // 4: start during SHIFT is ignored
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy", 32'(busy), 32'(1));
        wait_done();
        chk_res("t4", 8'h46, 1'b0);
        @(negedge clk);

        // 5: reset mid-operation
        a = 8'hA5; b = 8'h5A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_done", 32'(done), 32'(0));
        chk_res("t5_rst", 8'h00, 1'b0);
        repeat (W + 2) @(negedge clk);
        do_op(8'h0F, 8'h01, 1'b0); chk_res("t5", 8'h10, 1'b0);
        @(negedge clk);

        // 6: back-to-back from the done cycle
        do_op(8'h80, 8'h80, 1'b0); chk_res("t6a", 8'h00, 1'b1);
        a = 8'h01; b = 8'h02; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'(1));
        chk_res("t6_hold", 8'h00, 1'b1);
        wait_done();
        chk_res("t6b", 8'h04, 1'b0);

        // random regression, some back-to-back and some with idle gaps
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc);
            chk_res("rand", rs[W-1:0], rs[W]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
